// File: rtl/uart_pkg.sv
// uart_pkg: items shared by the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   MID_TICK   : oversample tick at the middle of the start bit
//   DATA_TICK  : last oversample tick of a data bit, where the line is sampled
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int MID_TICK  = 7;
    localparam int DATA_TICK = 15;

endpackage

// File: rtl/counter.sv
// counter: free-running modulo counter that produces the 16x oversample tick.
//   clk  : clock
//   rst  : synchronous active-high reset
//   tick : one-cycle pulse each time the count reaches COUNTER_MOD-1
module counter #(
    parameter int NB_COUNTER  = 9,
    parameter int COUNTER_MOD = 326
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [NB_COUNTER-1:0] LAST = NB_COUNTER'(COUNTER_MOD - 1);

    logic [NB_COUNTER-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + NB_COUNTER'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo.sv
// fifo: first-word-fall-through FIFO, depth 2**NB_ADDR.
//   clk   : clock
//   rst   : synchronous active-high reset (pointers and flags only)
//   wr    : push wdata (ignored when full unless popping in the same cycle)
//   rd    : pop head (ignored when empty)
//   wdata : write word
//   rdata : head word, mem[rd_ptr], combinational
//   empty : no words stored
//   full  : 2**NB_ADDR words stored
module fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic               rd,
    input  logic [NB_DATA-1:0] wdata,
    output logic [NB_DATA-1:0] rdata,
    output logic               empty,
    output logic               full
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];
    logic [NB_ADDR-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [NB_ADDR-1:0] wr_ptr_inc, rd_ptr_inc;
    logic               empty_n, full_n;
    logic               wr_en, rd_en;

    // A write while full is only accepted alongside a pop, which frees the slot.
    // A read while empty never happens, so simultaneous access on an empty
    // FIFO degenerates to a plain write.
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;

    assign wr_ptr_inc = wr_ptr + NB_ADDR'(1);
    assign rd_ptr_inc = rd_ptr + NB_ADDR'(1);

    always_comb begin
        wr_ptr_n = wr_en ? wr_ptr_inc : wr_ptr;
        rd_ptr_n = rd_en ? rd_ptr_inc : rd_ptr;
        empty_n  = empty;
        full_n   = full;
        if (wr_en && !rd_en) begin
            empty_n = 1'b0;
            full_n  = (wr_ptr_inc == rd_ptr);
        end else if (rd_en && !wr_en) begin
            full_n  = 1'b0;
            empty_n = (rd_ptr_inc == wr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            empty  <= empty_n;
            full   <= full_n;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8N1-style, LSB first).
//   clk     : clock
//   rst     : synchronous active-high reset
//   rx      : serial line, idle high
//   tick    : 16x oversample tick
//   rx_done : one-cycle pulse when a byte has been received
//   dout    : received byte, valid while rx_done is high
//
// The stop bit is timed but not checked; every frame is delivered.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_TCOUNT = 4,
    parameter int SB_TICK   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               tick,
    output logic               rx_done,
    output logic [NB_DATA-1:0] dout
);

    localparam int NB_IDX = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TCOUNT-1:0] S_MID  = NB_TCOUNT'(MID_TICK);
    localparam logic [NB_TCOUNT-1:0] S_DATA = NB_TCOUNT'(DATA_TICK);
    localparam logic [NB_TCOUNT-1:0] S_STOP = NB_TCOUNT'(SB_TICK - 1);
    localparam logic [NB_IDX-1:0]    N_LAST = NB_IDX'(NB_DATA - 1);

    rx_state_t            state, state_n;
    logic [NB_TCOUNT-1:0] s, s_n;
    logic [NB_IDX-1:0]    n, n_n;
    logic [NB_DATA-1:0]   b, b_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        rx_done = 1'b0;
        case (state)
            // Start edge is detected on any clock, not just on ticks.
            IDLE: begin
                if (!rx) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        state_n = DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + NB_TCOUNT'(1);
                    end
                end
            end
            // Sampling 16 ticks after mid-start lands in the middle of each bit.
            DATA: begin
                if (tick) begin
                    if (s == S_DATA) begin
                        s_n = '0;
                        b_n = {rx, b[NB_DATA-1:1]};
                        if (n == N_LAST) begin
                            state_n = STOP;
                        end else begin
                            n_n = n + NB_IDX'(1);
                        end
                    end else begin
                        s_n = s + NB_TCOUNT'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        state_n = IDLE;
                        rx_done = 1'b1;
                    end else begin
                        s_n = s + NB_TCOUNT'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dout = b;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a FWFT receive FIFO.
//   clk     : clock
//   i_rst   : synchronous active-high reset
//   i_rx    : serial line, idle high
//   i_rd    : pop the FIFO head
//   o_rdata : FIFO head word
//   o_empty : FIFO empty
//   o_full  : FIFO full
module uart_rx_fifo #(
    parameter int NB_COUNTER  = 9,
    parameter int COUNTER_MOD = 326,
    parameter int NB_DATA     = 8,
    parameter int NB_TCOUNT   = 4,
    parameter int SB_TICK     = 16,
    parameter int NB_ADDR     = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_empty,
    output logic               o_full
);

    logic               tick;
    logic               rx_done;
    logic [NB_DATA-1:0] rx_data;

    counter #(
        .NB_COUNTER (NB_COUNTER),
        .COUNTER_MOD(COUNTER_MOD)
    ) u_cnt (
        .clk (clk),
        .rst (i_rst),
        .tick(tick)
    );

    uart_rx #(
        .NB_DATA  (NB_DATA),
        .NB_TCOUNT(NB_TCOUNT),
        .SB_TICK  (SB_TICK)
    ) u_rx (
        .clk    (clk),
        .rst    (i_rst),
        .rx     (i_rx),
        .tick   (tick),
        .rx_done(rx_done),
        .dout   (rx_data)
    );

    fifo #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) u_fifo (
        .clk  (clk),
        .rst  (i_rst),
        .wr   (rx_done),
        .rd   (i_rd),
        .wdata(rx_data),
        .rdata(o_rdata),
        .empty(o_empty),
        .full (o_full)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. The tick divisor is shortened so a
// bit lasts 16*COUNTER_MOD clocks and the whole run stays short.
module tb_uart_rx_fifo;

    localparam int CMOD    = 3;
    localparam int BIT_CLK = 16 * CMOD;

    logic       clk = 1'b0;
    logic       i_rst, i_rx, i_rd;
    logic [7:0] o_rdata;
    logic       o_empty, o_full;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    uart_rx_fifo #(
        .NB_COUNTER (9),
        .COUNTER_MOD(CMOD),
        .NB_DATA    (8),
        .NB_TCOUNT  (4),
        .SB_TICK    (16),
        .NB_ADDR    (4)
    ) dut (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_rx   (i_rx),
        .i_rd   (i_rd),
        .o_rdata(o_rdata),
        .o_empty(o_empty),
        .o_full (o_full)
    );

    always #5 clk = ~clk;

    // Cycles with rx_done high; a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (dut.u_rx.rx_done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        i_rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic pop();
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
    endtask

    initial begin
        int          ticks;
        int          d0;
        logic [7:0]  seq4 [4];
        logic [31:0] w, r;

        i_rst = 1'b1;
        i_rx  = 1'b1;
        i_rd  = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        // Idle line after reset
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            if (dut.u_cnt.tick) ticks++;
            @(negedge clk);
        end
        chk("tick_rate", 32'(ticks), 32'd100);

        // Single byte
        d0 = done_cnt;
        send_byte(8'hA5);
        chk("a5_done", 32'(done_cnt - d0), 32'd1);
        chk("a5_data", 32'(o_rdata), 32'hA5);
        chk("a5_empty", 32'(o_empty), 32'd0);
        pop();
        chk("a5_pop_empty", 32'(o_empty), 32'd1);

        // Back-to-back bytes, FIFO order
        seq4[0] = 8'h3C; seq4[1] = 8'h81; seq4[2] = 8'hFF; seq4[3] = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(seq4[i]);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_data%0d", i), 32'(o_rdata), 32'(seq4[i]));
            pop();
        end
        chk("seq_empty", 32'(o_empty), 32'd1);

        // Fill to full, 17th byte dropped
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("fill_full16", 32'(o_full), 32'd1);
        send_byte(8'h10);
        chk("fill_full17", 32'(o_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_data%0d", i), 32'(o_rdata), 32'(i));
            pop();
        end
        chk("fill_empty", 32'(o_empty), 32'd1);
        chk("fill_notfull", 32'(o_full), 32'd0);

        // Reset in the middle of a data bit
        send_byte(8'h11);
        chk("pre_rst_empty", 32'(o_empty), 32'd0);
        i_rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        i_rx = 1'b1; repeat (BIT_CLK) @(negedge clk);
        i_rx = 1'b0; repeat (BIT_CLK) @(negedge clk);
        i_rx = 1'b1; repeat (BIT_CLK / 2) @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (4 * BIT_CLK) @(negedge clk);
        chk("mid_rst_empty", 32'(o_empty), 32'd1);
        send_byte(8'h5A);
        chk("mid_rst_data", 32'(o_rdata), 32'h5A);
        pop();
        chk("mid_rst_only", 32'(o_empty), 32'd1);

        // Random 32-bit words, LSB byte first
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
            r = '0;
            for (int j = 0; j < 4; j++) begin
                r[8*j +: 8] = o_rdata;
                pop();
            end
            chk($sformatf("rand_word%0d", k), r, w);
        end
        chk("rand_empty", 32'(o_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
